// File: rtl/choreo8_det_pkg.sv
// Shared constants and frame helpers for the Choreo8 pattern detector.
package choreo8_det_pkg;

   localparam logic [2:0] PAT_KNIGHT    = 3'd0;
   localparam logic [2:0] PAT_WALK_PAIR = 3'd1;
   localparam logic [2:0] PAT_EXPAND    = 3'd2;
   localparam logic [2:0] PAT_BLINK     = 3'd3;
   localparam logic [2:0] PAT_ALTERNATE = 3'd4;
   localparam logic [2:0] PAT_MARQUEE   = 3'd5;
   localparam logic [2:0] PAT_SPARKLE   = 3'd6;
   localparam logic [2:0] PAT_ALL_OFF   = 3'd7;

   localparam logic ST_UNLOCKED = 1'b0;
   localparam logic ST_LOCKED   = 1'b1;

   // Element [0] is the first frame of each sequence.
   localparam logic [3:0][7:0] KNIGHT_FRAMES = {8'h18, 8'h24, 8'h42, 8'h81};
   localparam logic [7:0][7:0] EXPAND_SEQ    = {8'h00, 8'h18, 8'h3C, 8'h7E,
                                                8'hFF, 8'h7E, 8'h3C, 8'h18};
   localparam logic [7:0]      LFSR_TAPS     = 8'hB8;

   function automatic logic [7:0] rotl8(input logic [7:0] x);
      return {x[6:0], x[7]};
   endfunction

   function automatic logic [7:0] lfsr8_next(input logic [7:0] x);
      return {x[6:0], ^(x & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/led_step_matcher.sv
// Combinational transition check: which Choreo8 patterns could produce prev -> cur.
module led_step_matcher
   import choreo8_det_pkg::*;
(
   input  logic [7:0] prev,
   input  logic [7:0] cur,
   output logic [7:0] match
);

   localparam logic [7:0][7:0] EXPAND_NEXT = {EXPAND_SEQ[0], EXPAND_SEQ[7:1]};

   logic       k_prev_hit, k_cur_hit;
   logic [2:0] k_prev_idx, k_cur_idx;
   logic       w_prev_hit, w_cur_hit;
   logic [2:0] w_prev_idx, w_cur_idx;
   logic       expand_ok;

   always_comb begin
      k_prev_hit = 1'b0;
      k_cur_hit  = 1'b0;
      k_prev_idx = 3'd0;
      k_cur_idx  = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (prev == KNIGHT_FRAMES[i]) begin
            k_prev_hit = 1'b1;
            k_prev_idx = 3'(i);
         end
         if (cur == KNIGHT_FRAMES[i]) begin
            k_cur_hit = 1'b1;
            k_cur_idx = 3'(i);
         end
      end

      w_prev_hit = 1'b0;
      w_cur_hit  = 1'b0;
      w_prev_idx = 3'd0;
      w_cur_idx  = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (prev == (8'h03 << i)) begin
            w_prev_hit = 1'b1;
            w_prev_idx = 3'(i);
         end
         if (cur == (8'h03 << i)) begin
            w_cur_hit = 1'b1;
            w_cur_idx = 3'(i);
         end
      end

      // Frames that appear twice in the expand cycle accept either successor.
      expand_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (prev == EXPAND_SEQ[i] && cur == EXPAND_NEXT[i])
            expand_ok = 1'b1;
      end
   end

   always_comb begin
      match = 8'h00;
      match[PAT_KNIGHT] = k_prev_hit && k_cur_hit &&
         ((k_prev_idx + 3'd1 == k_cur_idx) || (k_cur_idx + 3'd1 == k_prev_idx) ||
          (k_prev_idx == k_cur_idx && (k_prev_idx == 3'd0 || k_prev_idx == 3'd3)));
      match[PAT_WALK_PAIR] = w_prev_hit && w_cur_hit &&
         ((w_prev_idx + 3'd1 == w_cur_idx) || (w_cur_idx + 3'd1 == w_prev_idx) ||
          (w_prev_idx == w_cur_idx && (w_prev_idx == 3'd0 || w_prev_idx == 3'd6)));
      match[PAT_EXPAND]    = expand_ok;
      match[PAT_BLINK]     = (prev == 8'hFF && cur == 8'h00) || (prev == 8'h00 && cur == 8'hFF);
      match[PAT_ALTERNATE] = (prev == 8'hAA && cur == 8'h55) || (prev == 8'h55 && cur == 8'hAA);
      match[PAT_MARQUEE]   = (cur == rotl8(prev)) &&
         !(prev == 8'h00 || prev == 8'hFF || prev == 8'hAA || prev == 8'h55);
      match[PAT_SPARKLE]   = (cur == lfsr8_next(prev)) && (prev != 8'h00);
      match[PAT_ALL_OFF]   = (prev == 8'h00) && (cur == 8'h00);
   end

endmodule

// File: rtl/led_pattern_detector.sv
// Identifies which Choreo8 pattern an LED frame stream shows, with lock and change reporting.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   UNLOCKED    | no pattern held; lock on the lowest-index candidate that qualifies
//   LOCKED      | det_pat held; switch on a new qualifier, drop after UNLOCK_CNT misses
module led_pattern_detector
   import choreo8_det_pkg::*;
#(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] led_in,
   input  logic       led_valid,
   output logic [2:0] det_pat,
   output logic       det_locked,
   output logic       det_change
);

   localparam logic [3:0] LOCK_TC   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_TC = 4'(UNLOCK_CNT);

   logic            state;
   logic [7:0]      prev;
   logic            have_prev;
   logic [7:0][3:0] run;
   logic [3:0]      miss;

   logic [7:0]      match;
   logic [7:0][3:0] run_next;
   logic [7:0]      qual;
   logic            any_qual;
   logic [2:0]      winner;
   logic            step;

   assign step = ena & led_valid;

   led_step_matcher u_matcher (
      .prev  (prev),
      .cur   (led_in),
      .match (match)
   );

   always_comb begin
      run_next = '0;
      qual     = 8'h00;
      any_qual = 1'b0;
      winner   = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (match[k])
            run_next[k] = (run[k] >= LOCK_TC) ? LOCK_TC : run[k] + 4'd1;
         qual[k] = (run_next[k] == LOCK_TC);
      end
      for (int k = 7; k >= 0; k--) begin
         if (qual[k]) begin
            any_qual = 1'b1;
            winner   = 3'(k);
         end
      end
   end

   assign det_locked = (state == ST_LOCKED);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_UNLOCKED;
         prev       <= 8'h00;
         have_prev  <= 1'b0;
         run        <= '0;
         miss       <= 4'd0;
         det_pat    <= 3'd0;
         det_change <= 1'b0;
      end else begin
         det_change <= 1'b0;
         if (step) begin
            prev <= led_in;
            if (!have_prev) begin
               have_prev <= 1'b1;
            end else begin
               run <= run_next;
               case (state)
                  ST_UNLOCKED: begin
                     if (any_qual) begin
                        state      <= ST_LOCKED;
                        det_pat    <= winner;
                        miss       <= 4'd0;
                        det_change <= 1'b1;
                     end
                  end
                  ST_LOCKED: begin
                     // A locked pattern that misses cannot itself qualify, so any
                     // qualifier here is a different pattern.
                     if (match[det_pat]) begin
                        miss <= 4'd0;
                     end else if (any_qual) begin
                        det_pat    <= winner;
                        miss       <= 4'd0;
                        det_change <= 1'b1;
                     end else if (miss + 4'd1 == UNLOCK_TC) begin
                        state      <= ST_UNLOCKED;
                        miss       <= 4'd0;
                        det_change <= 1'b1;
                     end else begin
                        miss <= miss + 4'd1;
                     end
                  end
                  default: state <= ST_UNLOCKED;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_detector.sv
// Directed bench for led_pattern_detector; one instance at default thresholds, one with UNLOCK_CNT=6.
module tb_led_pattern_detector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] led_in;
   logic       led_valid;
   logic [2:0] pat_a, pat_b;
   logic       locked_a, locked_b;
   logic       chg_a, chg_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   led_pattern_detector dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .led_in     (led_in),
      .led_valid  (led_valid),
      .det_pat    (pat_a),
      .det_locked (locked_a),
      .det_change (chg_a)
   );

   led_pattern_detector #(.LOCK_CNT(4), .UNLOCK_CNT(6)) dut_u6 (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .led_in     (led_in),
      .led_valid  (led_valid),
      .det_pat    (pat_b),
      .det_locked (locked_b),
      .det_change (chg_b)
   );

   // Compared value is {det_pat, det_locked, det_change}.
   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed pat/lock/chg=%b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [7:0] v);
      ena       = 1'b1;
      led_in    = v;
      led_valid = 1'b1;
      @(negedge clk);
      led_valid = 1'b0;
   endtask

   task automatic idle();
      led_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic reset_one();
      rst_n     = 1'b0;
      ena       = 1'b1;
      led_in    = 8'hFF;
      led_valid = 1'b1;
      @(negedge clk);
      rst_n     = 1'b1;
      led_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      ena       = 1'b1;
      led_in    = 8'h00;
      led_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset_a", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      chk("reset_b", {pat_b, locked_b, chg_b}, {3'd0, 1'b0, 1'b0});

      // Knight: lock only on the fifth frame
      step(8'h81); chk("knight_f1", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      step(8'h42); chk("knight_f2", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      step(8'h24); chk("knight_f3", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      step(8'h18); chk("knight_f4", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      step(8'h18); chk("knight_lock", {pat_a, locked_a, chg_a}, {3'd0, 1'b1, 1'b1});

      // Freeze: ena low with led_valid toggling; change pulse must still clear
      for (int i = 0; i < 10; i++) begin
         ena       = 1'b0;
         led_valid = i[0];
         led_in    = 8'h3C ^ 8'(i);
         @(negedge clk);
         chk("freeze", {pat_a, locked_a, chg_a}, {3'd0, 1'b1, 1'b0});
      end
      led_valid = 1'b0;
      step(8'h24); chk("post_freeze", {pat_a, locked_a, chg_a}, {3'd0, 1'b1, 1'b0});

      // Reset mid-lock, with a strobe present during reset
      reset_one();
      chk("midreset", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});

      // Blink: relock needs five fresh frames, then stall to unlock
      step(8'hFF); chk("blink_f1", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      step(8'h00); chk("blink_f2", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      step(8'hFF); chk("blink_f3", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      step(8'h00); chk("blink_f4", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      step(8'hFF); chk("blink_lock", {pat_a, locked_a, chg_a}, {3'd3, 1'b1, 1'b1});
      step(8'hFF); chk("blink_miss1", {pat_a, locked_a, chg_a}, {3'd3, 1'b1, 1'b0});
      step(8'hFF); chk("blink_unlock", {pat_a, locked_a, chg_a}, {3'd3, 1'b0, 1'b1});
      idle();      chk("blink_idle", {pat_a, locked_a, chg_a}, {3'd3, 1'b0, 1'b0});

      // Marquee and sparkle agree until 08 -> 11, which only sparkle explains
      step(8'h01); chk("ms_f1", {pat_a, locked_a, chg_a}, {3'd3, 1'b0, 1'b0});
      step(8'h02); chk("ms_f2", {pat_a, locked_a, chg_a}, {3'd3, 1'b0, 1'b0});
      step(8'h04); chk("ms_f3", {pat_a, locked_a, chg_a}, {3'd3, 1'b0, 1'b0});
      step(8'h08); chk("ms_f4", {pat_a, locked_a, chg_a}, {3'd3, 1'b0, 1'b0});
      step(8'h11); chk("ms_lock6", {pat_a, locked_a, chg_a}, {3'd6, 1'b1, 1'b1});

      // Locked marquee switches to sparkle on a single miss
      reset_one();
      step(8'h0A); step(8'h14); step(8'h28);
      step(8'h50); chk("mq_f4", {pat_a, locked_a, chg_a}, {3'd0, 1'b0, 1'b0});
      step(8'hA0); chk("mq_lock5", {pat_a, locked_a, chg_a}, {3'd5, 1'b1, 1'b1});
      step(8'h41); chk("mq_hold1", {pat_a, locked_a, chg_a}, {3'd5, 1'b1, 1'b0});
      step(8'h82); chk("mq_hold2", {pat_a, locked_a, chg_a}, {3'd5, 1'b1, 1'b0});
      step(8'h05); chk("mq_hold3", {pat_a, locked_a, chg_a}, {3'd5, 1'b1, 1'b0});
      step(8'h0A); chk("mq_hold4", {pat_a, locked_a, chg_a}, {3'd5, 1'b1, 1'b0});
      step(8'h15); chk("mq_switch6", {pat_a, locked_a, chg_a}, {3'd6, 1'b1, 1'b1});

      // Alternate then marquee: UNLOCK_CNT=6 switches seamlessly, UNLOCK_CNT=2 drops first
      reset_one();
      step(8'hAA); step(8'h55); step(8'hAA); step(8'h55);
      chk("alt_f4_b", {pat_b, locked_b, chg_b}, {3'd0, 1'b0, 1'b0});
      step(8'hAA);
      chk("alt_lock_b", {pat_b, locked_b, chg_b}, {3'd4, 1'b1, 1'b1});
      chk("alt_lock_a", {pat_a, locked_a, chg_a}, {3'd4, 1'b1, 1'b1});
      step(8'h07);
      chk("sw_07_b", {pat_b, locked_b, chg_b}, {3'd4, 1'b1, 1'b0});
      chk("sw_07_a", {pat_a, locked_a, chg_a}, {3'd4, 1'b1, 1'b0});
      step(8'h0E);
      chk("sw_0e_b", {pat_b, locked_b, chg_b}, {3'd4, 1'b1, 1'b0});
      chk("sw_0e_a", {pat_a, locked_a, chg_a}, {3'd4, 1'b0, 1'b1});
      step(8'h1C);
      chk("sw_1c_b", {pat_b, locked_b, chg_b}, {3'd4, 1'b1, 1'b0});
      chk("sw_1c_a", {pat_a, locked_a, chg_a}, {3'd4, 1'b0, 1'b0});
      step(8'h38);
      chk("sw_38_b", {pat_b, locked_b, chg_b}, {3'd4, 1'b1, 1'b0});
      step(8'h70);
      chk("sw_70_b", {pat_b, locked_b, chg_b}, {3'd5, 1'b1, 1'b1});
      chk("sw_70_a", {pat_a, locked_a, chg_a}, {3'd5, 1'b1, 1'b1});
      idle();
      chk("sw_idle_b", {pat_b, locked_b, chg_b}, {3'd5, 1'b1, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
